// File: rtl/dfmul_run_ctrl.sv
// Run controller for the DFMUL self-test top: repeats the self-test, gathers statistics, and
// guards each run with a watchdog. Define DFMUL_RUNCTRL_ERRSUM_EN to build the err_total sum.
module dfmul_run_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned WD_W           = 13,
   parameter logic [31:0] EXPECTED       = 32'd0
) (
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        cmd_start,
   input  logic [7:0]  cmd_runs,
   output logic        dut_ap_start,
   input  logic        dut_ap_done,
   input  logic        dut_ap_ready,
   input  logic [31:0] dut_ap_return,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [7:0]  fail_runs,
   output logic [15:0] err_total,
   output logic [31:0] last_result
);

   typedef enum logic [1:0] {StIdle, StRun, StCheck, StFin} state_e;

   localparam logic [WD_W-1:0] WdLast = WD_W'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic [7:0]      runs_q, runs_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            timeout_q, timeout_d;
   logic [7:0]      fail_q, fail_d;
   logic [31:0]     last_q, last_d;
   logic            stat_clr;
   logic            chk_en;

   // Ready always coincides with done, so done alone qualifies the capture.
   logic unused_ready;
   assign unused_ready = dut_ap_ready;

   always_comb begin
      state_d   = state_q;
      runs_d    = runs_q;
      wd_d      = wd_q;
      start_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      fail_d    = fail_q;
      last_d    = last_q;
      stat_clr  = 1'b0;
      chk_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_start) begin
               busy_d = 1'b1;
               if (cmd_runs == 8'd0) begin
                  state_d = StFin;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d   = StRun;
                  runs_d    = cmd_runs;
                  wd_d      = '0;
                  start_d   = 1'b1;
                  stat_clr  = 1'b1;
                  fail_d    = 8'd0;
                  last_d    = 32'd0;
                  timeout_d = 1'b0;
                  pass_d    = 1'b0;
               end
            end
         end
         StRun: begin
            busy_d = 1'b1;
            wd_d   = wd_q + 1'b1;
            if (dut_ap_done) begin
               last_d  = dut_ap_return;
               state_d = StCheck;
            end else if (wd_q == WdLast) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = StFin;
            end else begin
               start_d = 1'b1;
            end
         end
         StCheck: begin
            busy_d = 1'b1;
            chk_en = 1'b1;
            wd_d   = '0;
            runs_d = runs_q - 8'd1;
            if ((last_q != EXPECTED) && (fail_q != 8'hFF)) begin
               fail_d = fail_q + 8'd1;
            end
            if (runs_q == 8'd1) begin
               state_d = StFin;
               done_d  = 1'b1;
               pass_d  = (fail_d == 8'd0) && !timeout_q;
            end else begin
               state_d = StRun;
               start_d = 1'b1;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= StIdle;
         runs_q    <= 8'd0;
         wd_q      <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         fail_q    <= 8'd0;
         last_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         runs_q    <= runs_d;
         wd_q      <= wd_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         fail_q    <= fail_d;
         last_q    <= last_d;
      end
   end

`ifdef DFMUL_RUNCTRL_ERRSUM_EN
   logic [15:0] err_q;
   logic [32:0] err_sum;

   // Widened so a full 32-bit result cannot wrap before the clamp.
   assign err_sum = 33'(err_q) + 33'(last_q);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         err_q <= 16'd0;
      end else if (stat_clr) begin
         err_q <= 16'd0;
      end else if (chk_en) begin
         err_q <= (err_sum > 33'h0_0000_FFFF) ? 16'hFFFF : err_sum[15:0];
      end
   end

   assign err_total = err_q;
`else
   logic unused_err_ctrl;
   assign unused_err_ctrl = stat_clr ^ chk_en;
   assign err_total       = 16'd0;
`endif

   assign dut_ap_start = start_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timeout      = timeout_q;
   assign fail_runs    = fail_q;
   assign last_result  = last_q;

endmodule

// File: tb/tb_dfmul_run_ctrl.sv
// Self-checking bench for dfmul_run_ctrl: table of campaigns against a behavioural DFMUL top,
// plus directed timing sequences for handshake, watchdog and asynchronous reset.
module tb_dfmul_run_ctrl;

`ifdef DFMUL_RUNCTRL_ERRSUM_EN
   localparam bit ErrSumEn = 1'b1;
`else
   localparam bit ErrSumEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_start = 1'b0;
   logic [7:0]  cmd_runs = 8'd0;
   logic        dut_start;
   logic        m_done;
   logic [31:0] m_ret;
   logic        busy, done, pass, timeout;
   logic [7:0]  fail_runs;
   logic [15:0] err_total;
   logic [31:0] last_result;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural DFMUL top
   logic [31:0] rets [4];
   int          lat  = 40;
   bit          hang = 1'b0;
   int          m_cnt;
   int          hs_cnt;

   always #5 clk = ~clk;

   dfmul_run_ctrl #(
      .TIMEOUT_CYCLES(64),
      .WD_W          (7),
      .EXPECTED      (32'd0)
   ) dut (
      .ap_clk       (clk),
      .ap_rst_n     (rst_n),
      .cmd_start    (cmd_start),
      .cmd_runs     (cmd_runs),
      .dut_ap_start (dut_start),
      .dut_ap_done  (m_done),
      .dut_ap_ready (m_done),
      .dut_ap_return(m_ret),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .timeout      (timeout),
      .fail_runs    (fail_runs),
      .err_total    (err_total),
      .last_result  (last_result)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         hs_cnt <= 0;
         m_done <= 1'b0;
         m_ret  <= 32'd0;
      end else begin
         m_done <= 1'b0;
         if (dut_start && !m_done && !hang) begin
            if (m_cnt == lat - 1) begin
               m_done <= 1'b1;
               m_ret  <= rets[hs_cnt % 4];
               hs_cnt <= hs_cnt + 1;
               m_cnt  <= 0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end else if (!dut_start) begin
            m_cnt <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic campaign(input logic [7:0] runs, output int n_done, output int n_hs);
      logic prev;
      int   extra;
      n_done = 0;
      n_hs   = 0;
      prev   = 1'b0;
      extra  = 0;
      @(negedge clk);
      cmd_runs  = runs;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (dut_start && !prev) n_hs++;
         prev = dut_start;
         if (done) begin
            n_done++;
            break;
         end
         @(negedge clk);
      end
      if (n_done == 0) $display("FAIL campaign_bound: no done within 3000 cycles");
      @(negedge clk);
      chk("busy_after_fin", {31'd0, busy}, 32'd0);
      chk("start_after_fin", {31'd0, dut_start}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         if (done) extra++;
         @(negedge clk);
      end
      chk("no_extra_done", extra, 0);
   endtask

   typedef struct {
      logic [7:0]  runs;
      int          lat;
      bit          hang;
      logic [31:0] r0, r1, r2;
      int          hs;
      logic [7:0]  fail;
      logic [15:0] err;
      logic [31:0] last;
      logic        pss;
      logic        tmo;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int n_done, n_hs;
      int d1, d2, done_at;
      logic s_start [64];
      logic s_mdone [64];
      logic s_done  [64];
      logic s_busy  [64];
      logic [31:0] s_last [64];

      vecs[0] = '{8'd3, 40, 1'b0, 32'd0, 32'd0, 32'd0, 3, 8'd0, 16'd0, 32'd0, 1'b1, 1'b0};
      vecs[1] = '{8'd3, 40, 1'b0, 32'd5, 32'd0, 32'd7, 3, 8'd2, 16'd12, 32'd7, 1'b0, 1'b0};
      vecs[2] = '{8'd2, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2, 8'd2, 16'hFFFF,
                  32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[3] = '{8'd1, 1, 1'b0, 32'd3, 32'd0, 32'd0, 1, 8'd1, 16'd3, 32'd3, 1'b0, 1'b0};
      vecs[4] = '{8'd0, 40, 1'b0, 32'd0, 32'd0, 32'd0, 0, 8'd0, 16'd0, 32'd0, 1'b1, 1'b0};
      vecs[5] = '{8'd2, 40, 1'b1, 32'd0, 32'd0, 32'd0, 1, 8'd0, 16'd0, 32'd0, 1'b0, 1'b1};

      rets[0] = 32'd0; rets[1] = 32'd0; rets[2] = 32'd0; rets[3] = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_start", {31'd0, dut_start}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_fail", {24'd0, fail_runs}, 32'd0);
      chk("rst_err", {16'd0, err_total}, 32'd0);
      chk("rst_last", last_result, 32'd0);
      rst_n = 1'b1;

      // Campaign table
      for (int i = 0; i < 6; i++) begin
         lat     = vecs[i].lat;
         hang    = vecs[i].hang;
         rets[0] = vecs[i].r0;
         rets[1] = vecs[i].r1;
         rets[2] = vecs[i].r2;
         do_reset();
         campaign(vecs[i].runs, n_done, n_hs);
         chk($sformatf("v%0d_done_count", i), n_done, 1);
         chk($sformatf("v%0d_handshakes", i), n_hs, vecs[i].hs);
         chk($sformatf("v%0d_fail_runs", i), {24'd0, fail_runs}, {24'd0, vecs[i].fail});
         chk($sformatf("v%0d_err_total", i), {16'd0, err_total},
             ErrSumEn ? {16'd0, vecs[i].err} : 32'd0);
         chk($sformatf("v%0d_last_result", i), last_result, vecs[i].last);
         chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].pss});
         chk($sformatf("v%0d_timeout", i), {31'd0, timeout}, {31'd0, vecs[i].tmo});
      end

      // New campaign clears the sticky timeout left by the last vector
      hang = 1'b0;
      lat  = 4;
      rets[0] = 32'd0; rets[1] = 32'd0; rets[2] = 32'd0; rets[3] = 32'd0;
      campaign(8'd1, n_done, n_hs);
      chk("clr_timeout", {31'd0, timeout}, 32'd0);
      chk("clr_pass", {31'd0, pass}, 32'd1);

      // cmd_runs=0: done at T+1, no start
      do_reset();
      @(negedge clk);
      cmd_runs  = 8'd0;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("zero_done_t1", {31'd0, done}, 32'd1);
      chk("zero_pass_t1", {31'd0, pass}, 32'd1);
      chk("zero_start_t1", {31'd0, dut_start}, 32'd0);
      chk("zero_busy_t1", {31'd0, busy}, 32'd1);

      // Handshake timing around done at D
      lat     = 3;
      rets[0] = 32'd9;
      rets[1] = 32'd0;
      do_reset();
      @(negedge clk);
      cmd_runs  = 8'd2;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      for (int c = 0; c < 64; c++) begin
         s_start[c] = dut_start;
         s_mdone[c] = m_done;
         s_done[c]  = done;
         s_busy[c]  = busy;
         s_last[c]  = last_result;
         @(negedge clk);
      end
      chk("t1_start", {31'd0, s_start[0]}, 32'd1);
      chk("t1_busy", {31'd0, s_busy[0]}, 32'd1);
      d1 = -1;
      d2 = -1;
      for (int c = 0; c < 60; c++) begin
         if (s_mdone[c] && d1 < 0) d1 = c;
         else if (s_mdone[c] && d1 >= 0 && d2 < 0) d2 = c;
      end
      chk("hs_two_dones_seen", {31'd0, (d1 >= 0 && d2 >= 0)}, 32'd1);
      if (d1 >= 0 && d2 >= 0) begin
         chk("d1_start_low", {31'd0, s_start[d1+1]}, 32'd0);
         chk("d1_last", s_last[d1+1], 32'd9);
         chk("d2_restart", {31'd0, s_start[d1+2]}, 32'd1);
         chk("d_last_no_done", {31'd0, s_done[d2+1]}, 32'd0);
         chk("d_last_done", {31'd0, s_done[d2+2]}, 32'd1);
         chk("d_last_busy_fin", {31'd0, s_busy[d2+2]}, 32'd1);
         chk("d_last_busy_off", {31'd0, s_busy[d2+3]}, 32'd0);
      end

      // Watchdog: FIN at S+64, cmd_start inside RUN ignored
      hang = 1'b1;
      do_reset();
      @(negedge clk);
      cmd_runs  = 8'd1;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      done_at = -1;
      for (int k = 0; k < 100; k++) begin
         if (done) begin
            done_at = k;
            chk("wd_start_at_fin", {31'd0, dut_start}, 32'd0);
            chk("wd_timeout", {31'd0, timeout}, 32'd1);
            chk("wd_pass", {31'd0, pass}, 32'd0);
            break;
         end
         if (k == 10) begin
            cmd_runs  = 8'd0;
            cmd_start = 1'b1;
         end else begin
            cmd_start = 1'b0;
         end
         @(negedge clk);
      end
      cmd_start = 1'b0;
      chk("wd_done_cycle", done_at, 64);
      @(negedge clk);
      chk("wd_start_after", {31'd0, dut_start}, 32'd0);

      // Asynchronous reset mid-RUN
      do_reset();
      @(negedge clk);
      cmd_runs  = 8'd3;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_start_high", {31'd0, dut_start}, 32'd1);
      chk("mid_busy_high", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_start", {31'd0, dut_start}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_pass", {31'd0, pass}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hang  = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_idle_start", {31'd0, dut_start}, 32'd0);
      chk("arst_idle_busy", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
